// File: rtl/bf_step_counter.sv
// Registered up/down counter with run-length step, load/clear, wrap or saturate,
// sticky over/underflow flags and a single-entry valid/ready result register.
module bf_step_counter #(
    parameter int              WIDTH     = 16,
    parameter int              STEP_W    = 8,
    parameter int              SATURATE  = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] value,
    output logic             zero,
    output logic             ovf,
    output logic             unf
);

    localparam logic [2:0] OP_INC    = 3'd0;
    localparam logic [2:0] OP_DEC    = 3'd1;
    localparam logic [2:0] OP_ADD    = 3'd2;
    localparam logic [2:0] OP_SUB    = 3'd3;
    localparam logic [2:0] OP_LOAD   = 3'd4;
    localparam logic [2:0] OP_CLEAR  = 3'd5;
    localparam logic [2:0] OP_CLRFLG = 3'd6;
    localparam logic [2:0] OP_NOP    = 3'd7;

    logic             accept;
    logic [WIDTH:0]   val_ext;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] up_val;
    logic [WIDTH-1:0] dn_val;
    logic [WIDTH-1:0] nxt_val;
    logic             set_ovf;
    logic             set_unf;
    logic             clr_flags;

    assign cmd_ready = !res_valid || res_ready;
    assign accept    = cmd_valid && cmd_ready;
    assign zero      = (value == '0);

    assign val_ext  = {1'b0, value};
    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, cmd_operand[STEP_W-1:0]};
    assign addend   = (cmd_op == OP_INC || cmd_op == OP_DEC) ?
                      {{WIDTH{1'b0}}, 1'b1} : step_ext;
    assign sum      = val_ext + addend;
    assign diff     = val_ext - addend;

    // Bit WIDTH of the extended result is the carry (add) or borrow (sub).
    assign up_val = (SATURATE != 0 && sum[WIDTH])  ? '1 : sum[WIDTH-1:0];
    assign dn_val = (SATURATE != 0 && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];

    always_comb begin
        nxt_val   = value;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        clr_flags = 1'b0;
        case (cmd_op)
            OP_INC, OP_ADD: begin
                nxt_val = up_val;
                set_ovf = sum[WIDTH];
            end
            OP_DEC, OP_SUB: begin
                nxt_val = dn_val;
                set_unf = diff[WIDTH];
            end
            OP_LOAD:   nxt_val   = cmd_operand;
            OP_CLEAR:  nxt_val   = '0;
            OP_CLRFLG: clr_flags = 1'b1;
            OP_NOP:    nxt_val   = value;
            default:   nxt_val   = value;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value     <= RESET_VAL;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            res_valid <= 1'b0;
        end else if (accept) begin
            value     <= nxt_val;
            ovf       <= clr_flags ? 1'b0 : (ovf | set_ovf);
            unf       <= clr_flags ? 1'b0 : (unf | set_unf);
            res_valid <= 1'b1;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bf_step_counter.sv
// Scoreboard bench: a wrapping and a saturating 8-bit instance driven by the same
// command stream, each checked against an integer reference model.
module tb_bf_step_counter;

    localparam logic [7:0] RV0 = 8'h00;
    localparam logic [7:0] RV1 = 8'h5A;

    typedef struct {
        int val;
        int o;
        int u;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd7;
    logic [7:0] cmd_operand = 8'h00;
    logic       res_ready = 1'b0;

    logic       cmd_ready [2];
    logic       res_valid [2];
    logic [7:0] value [2];
    logic       zero [2];
    logic       ovf [2];
    logic       unf [2];

    int total = 0;
    int bad = 0;

    exp_t q [2][$];
    int   m_val [2];
    int   m_ovf [2];
    int   m_unf [2];
    bit   m_rv [2];

    always #5 clk = ~clk;

    bf_step_counter #(.WIDTH(8), .STEP_W(8), .SATURATE(0), .RESET_VAL(RV0)) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op),
        .cmd_operand(cmd_operand), .res_valid(res_valid[0]), .res_ready(res_ready),
        .value(value[0]), .zero(zero[0]), .ovf(ovf[0]), .unf(unf[0])
    );

    bf_step_counter #(.WIDTH(8), .STEP_W(8), .SATURATE(1), .RESET_VAL(RV1)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op),
        .cmd_operand(cmd_operand), .res_valid(res_valid[1]), .res_ready(res_ready),
        .value(value[1]), .zero(zero[1]), .ovf(ovf[1]), .unf(unf[1])
    );

    task automatic chk(input string name, input int d, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Reference behaviour: signed integer arithmetic, then range fix-up.
    task automatic model_apply(input int d, input logic [2:0] op, input logic [7:0] opnd);
        int n;
        n = m_val[d];
        case (op)
            3'd0: n = m_val[d] + 1;
            3'd1: n = m_val[d] - 1;
            3'd2: n = m_val[d] + int'(opnd);
            3'd3: n = m_val[d] - int'(opnd);
            3'd4: n = int'(opnd);
            3'd5: n = 0;
            3'd6: begin m_ovf[d] = 0; m_unf[d] = 0; end
            default: n = m_val[d];
        endcase
        if (n > 255) begin
            m_ovf[d] = 1;
            n = (d == 1) ? 255 : n - 256;
        end else if (n < 0) begin
            m_unf[d] = 1;
            n = (d == 1) ? 0 : n + 256;
        end
        m_val[d] = n;
    endtask

    task automatic cycle(input bit cv, input logic [2:0] op, input logic [7:0] opnd, input bit rr);
        bit exp_rdy;
        exp_t e;
        cmd_valid = cv;
        cmd_op = op;
        cmd_operand = opnd;
        res_ready = rr;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("res_valid", d, int'(res_valid[d]), int'(m_rv[d]));
            exp_rdy = !m_rv[d] || rr;
            chk("cmd_ready", d, int'(cmd_ready[d]), int'(exp_rdy));
            if (cv && exp_rdy) begin
                model_apply(d, op, opnd);
                e.val = m_val[d];
                e.o = m_ovf[d];
                e.u = m_unf[d];
                q[d].push_back(e);
                m_rv[d] = 1'b1;
            end else if (rr) begin
                m_rv[d] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        m_val[0] = int'(RV0);
        m_val[1] = int'(RV1);
        for (int d = 0; d < 2; d++) begin
            m_ovf[d] = 0;
            m_unf[d] = 0;
            m_rv[d] = 1'b0;
            q[d].delete();
            chk("rst_value", d, int'(value[d]), m_val[d]);
            chk("rst_res_valid", d, int'(res_valid[d]), 0);
            chk("rst_ovf", d, int'(ovf[d]), 0);
            chk("rst_unf", d, int'(unf[d]), 0);
            chk("rst_zero", d, int'(zero[d]), int'(m_val[d] == 0));
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) chk("rst_cmd_ready", d, int'(cmd_ready[d]), 1);
    endtask

    // Monitor: while a result is presented it must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                if (res_valid[d]) begin
                    if (q[d].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_result dut%0d: got value %0h expected none", d, value[d]);
                    end else begin
                        chk("value", d, int'(value[d]), q[d][0].val);
                        chk("zero", d, int'(zero[d]), int'(q[d][0].val == 0));
                        chk("ovf", d, int'(ovf[d]), q[d][0].o);
                        chk("unf", d, int'(unf[d]), q[d][0].u);
                        if (res_ready) void'(q[d].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // wrap through top, back-to-back
        cycle(1, 3'd4, 8'hFE, 1);
        cycle(1, 3'd0, 8'h00, 1);
        cycle(1, 3'd0, 8'h00, 1);
        cycle(0, 3'd7, 8'h00, 1);

        // underflow and saturation at both ends, step 0 is a no-op
        cycle(1, 3'd4, 8'h05, 1);
        cycle(1, 3'd3, 8'h08, 1);
        cycle(1, 3'd2, 8'hFF, 1);
        cycle(1, 3'd2, 8'h10, 1);
        cycle(1, 3'd6, 8'h00, 1);
        cycle(1, 3'd2, 8'h00, 1);
        cycle(1, 3'd3, 8'h00, 1);
        cycle(0, 3'd7, 8'h00, 1);

        // stall: result held, DEC waits until res_ready rises
        cycle(1, 3'd0, 8'h00, 0);
        cycle(1, 3'd1, 8'h00, 0);
        cycle(1, 3'd1, 8'h00, 0);
        cycle(1, 3'd1, 8'h00, 1);
        cycle(0, 3'd7, 8'h00, 1);

        // flag set by wrap, cleared, then a NOP result
        cycle(1, 3'd4, 8'hFF, 1);
        cycle(1, 3'd0, 8'h00, 1);
        cycle(1, 3'd6, 8'h00, 1);
        cycle(1, 3'd7, 8'h00, 1);
        cycle(0, 3'd7, 8'h00, 1);

        // reset while stalled with a command waiting
        cycle(1, 3'd4, 8'h33, 0);
        cycle(1, 3'd1, 8'h00, 0);
        cmd_valid = 1'b1;
        cmd_op = 3'd1;
        res_ready = 1'b0;
        do_reset();
        cycle(0, 3'd7, 8'h00, 1);

        for (int i = 0; i < 400; i++) begin
            logic [7:0] opnd;
            opnd = 8'($urandom);
            case ($urandom_range(0, 3))
                0: opnd = 8'h00;
                1: opnd = 8'($urandom_range(250, 255));
                default: ;
            endcase
            cycle($urandom_range(0, 9) < 7, 3'($urandom), opnd, $urandom_range(0, 9) < 7);
        end

        cycle(0, 3'd7, 8'h00, 1);
        cycle(0, 3'd7, 8'h00, 1);
        for (int d = 0; d < 2; d++) chk("drained", d, q[d].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bf_step_counter.md
Name: bf_step_counter

Overview:
Parametrised successor to the machine's fixed ±1 incrementers for the data pointer, data cell and PC. It is a registered up/down counter.
- Arithmetic: step size of 1 or a run-length operand (collapsed "+++"/">>>" runs), plus load and clear.
- Modes: wrap or saturate, selected by parameter.
- Flags: zero, plus sticky overflow/underflow.
- Handshake: valid/ready on both command input and result output.
One instance each serves as data pointer, cell value and PC in the next-generation datapath.

Parameters:
WIDTH, 16, counter/value width in bits (8 for cell, 16 for pointer/PC)
STEP_W, 8, width of run-length step operand
SATURATE, 0, 0 = modular wrap at 2^WIDTH; 1 = clamp at 0 / 2^WIDTH-1
RESET_VAL, 0, value loaded on reset (WIDTH bits)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  unit can accept command this cycle
cmd_op  in  3  operation code (see Behaviour)
cmd_operand  in  WIDTH  LOAD value; low STEP_W bits = ADD/SUB step
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
value  out  WIDTH  current counter register
zero  out  1  value == 0 (combinational from register)
ovf  out  1  sticky overflow (wrap/clamp at top)
unf  out  1  sticky underflow (wrap/clamp at bottom)

Behaviour:
- Reset (async, reset_n low):
  - value = RESET_VAL; ovf = unf = 0; res_valid = 0.
  - cmd_ready = 1 once reset_n is high.
  - Reset mid-transaction discards any pending result and the command in flight.
- Accept: a command is accepted when cmd_valid && cmd_ready at a rising edge.
  - cmd_ready = !res_valid || res_ready; single output register, no buffering beyond it.
- Latency: value, flags and res_valid update on the accepting edge. The result is visible the cycle after acceptance (1-cycle latency).
- Back-to-back: with res_ready held high, one command per cycle.
- res_valid handshake:
  - Stays high until res_valid && res_ready.
  - Commands stall (cmd_ready = 0) while res_valid is high and res_ready is low.
  - value is stable while stalled.
  - If res_ready and a new accept coincide, res_valid stays 1 and value takes the new result.
- cmd_op encoding:
  - 0 INC: value+1
  - 1 DEC: value-1
  - 2 ADD: value + zext(operand[STEP_W-1:0])
  - 3 SUB: value - zext(operand[STEP_W-1:0])
  - 4 LOAD: value = operand
  - 5 CLEAR: value = 0
  - 6 CLRFLG: ovf = unf = 0, value unchanged
  - 7 NOP: no change; still produces a result handshake
- Arithmetic:
  - Computed at WIDTH+1 bits; a carry/borrow out of bit WIDTH-1 is an overflow or underflow event.
  - SATURATE=0: result is the low WIDTH bits.
  - SATURATE=1: result clamps to 2^WIDTH-1 on overflow and 0 on underflow.
  - Step 0 on ADD/SUB: value unchanged, no flag event.
- Flags:
  - An overflow event sets ovf; an underflow event sets unf.
  - Both are sticky until CLRFLG or reset.
  - LOAD, CLEAR and NOP never set or clear flags.
- Commands produce results strictly in acceptance order.
- res_valid output is registered; cmd_ready is combinational from res_valid/res_ready only (no path from cmd_valid).

Test Plan:
- WIDTH=8, SATURATE=0, reset_n low then high -> value=0x00, zero=1, ovf=unf=0, res_valid=0, cmd_ready=1.
- LOAD 0xFE, INC, INC back-to-back with res_ready=1 -> values 0xFE, 0xFF, 0x00 on consecutive cycles; zero=1 at end; ovf=1; unf=0.
- SATURATE=1, LOAD 0x05, SUB step 0x08 -> value=0x00, unf=1; then ADD 0xFF, ADD 0x10 -> 0xFF then 0xFF, ovf=1.
- Hold res_ready=0 after one INC, drive cmd_valid=1 with DEC -> cmd_ready=0, value held; raise res_ready -> DEC accepted that edge, value decrements next cycle.
- Set ovf via wrap, then CLRFLG -> ovf=unf=0, value unchanged; following NOP yields res_valid pulse with unchanged value.
- Assert reset_n low mid-stall (res_valid=1, res_ready=0) -> immediately value=RESET_VAL, res_valid=0, flags 0, pending command dropped.
